// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end and producer side of the next-PC loop.
// Owns the fetch PC, issues req/gnt + rvalid memory requests, buffers one
// instruction toward decode and applies taken branch targets after the delay slot.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic        w_stall,
   input  logic        w_redirect,
   input  logic [31:0] w_next_pc_32,
   output logic [31:0] w_pc_32,
   output logic        w_imem_req,
   output logic [31:0] w_imem_addr_32,
   input  logic        w_imem_gnt,
   input  logic        w_imem_rvalid,
   input  logic [31:0] w_imem_rdata_32,
   output logic        w_inst_valid,
   output logic [31:0] w_inst_32,
   output logic [31:0] w_inst_pc_32,
   input  logic        w_inst_ready,
   output logic        w_fetch_err,
   output logic [31:0] w_perf_fetch_32,
   output logic [31:0] w_perf_stall_32
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] tgt_q;
   logic        pend_q;
   logic        err_q;
   logic        reqHold_q;
   logic        instValid_q;
   logic [31:0] inst_q;
   logic [31:0] instPc_q;

   logic        reqOut;
   logic        drain;
   logic        capture;
   logic        redirectTaken;
   logic        misaligned;

   // A redirect only counts when the instruction carrying it leaves the buffer;
   // a response is only accepted while a request is actually outstanding.
   assign drain         = instValid_q & w_inst_ready;
   assign redirectTaken = drain & w_redirect;
   assign misaligned    = redirectTaken & (w_next_pc_32[1:0] != 2'b00);
   assign capture       = (state_q == WAIT) & w_imem_rvalid;

   // State register: reset lands in IDLE immediately, even mid-transaction.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: the error state is entered only once the in-flight word (the delay slot) lands.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = REQ;
         REQ:     if (reqOut && w_imem_gnt) state_d = WAIT;
         WAIT:    if (capture) state_d = (err_q || misaligned) ? ERR : REQ;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   // Request output: a new request needs no stall and room in the buffer, but once raised it holds until granted.
   always_comb begin
      reqOut = 1'b0;
      if (state_q == REQ)
         reqOut = reqHold_q | (~w_stall & (~instValid_q | w_inst_ready));
   end

   // PC, pending branch target, sticky error and the one-entry instruction buffer.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         pc_q        <= RESET_PC;
         tgt_q       <= '0;
         pend_q      <= 1'b0;
         err_q       <= 1'b0;
         reqHold_q   <= 1'b0;
         instValid_q <= 1'b0;
         inst_q      <= '0;
         instPc_q    <= '0;
      end else begin
         reqHold_q <= reqOut & ~w_imem_gnt;
         if (capture) begin
            if (pend_q)             pc_q <= tgt_q;
            else if (redirectTaken) pc_q <= w_next_pc_32;
            else                    pc_q <= pc_q + 32'd4;
         end
         if (redirectTaken && !(capture && !pend_q)) begin
            tgt_q  <= w_next_pc_32;
            pend_q <= 1'b1;
         end else if (capture) begin
            pend_q <= 1'b0;
         end
         if (misaligned) err_q <= 1'b1;
         if (capture) begin
            inst_q      <= w_imem_rdata_32;
            instPc_q    <= pc_q;
            instValid_q <= 1'b1;
         end else if (drain) begin
            instValid_q <= 1'b0;
         end
      end
   end

   assign w_pc_32        = pc_q;
   assign w_imem_req     = reqOut;
   assign w_imem_addr_32 = pc_q;
   assign w_inst_valid   = instValid_q;
   assign w_inst_32      = inst_q;
   assign w_inst_pc_32   = instPc_q;
   assign w_fetch_err    = err_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perfFetch_q;
   logic [31:0] perfStall_q;

   // Count captured words and cycles lost to stall or a full, undrained buffer.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         perfFetch_q <= '0;
         perfStall_q <= '0;
      end else begin
         if (capture) perfFetch_q <= perfFetch_q + 32'd1;
         if (w_stall || ((state_q == REQ) && instValid_q && !w_inst_ready))
            perfStall_q <= perfStall_q + 32'd1;
      end
   end

   assign w_perf_fetch_32 = perfFetch_q;
   assign w_perf_stall_32 = perfStall_q;
`else
   assign w_perf_fetch_32 = 32'd0;
   assign w_perf_stall_32 = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The memory model grants every request and answers one cycle after the grant
// with the word 0xA500_0000 | address.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
   localparam int PERF_ON = 1;
`else
   localparam int PERF_ON = 0;
`endif

   logic        w_clk = 1'b0;
   logic        w_rst;
   logic        w_stall;
   logic        w_redirect;
   logic [31:0] w_next_pc_32;
   logic [31:0] w_pc_32;
   logic        w_imem_req;
   logic [31:0] w_imem_addr_32;
   logic        w_imem_gnt;
   logic        w_imem_rvalid;
   logic [31:0] w_imem_rdata_32;
   logic        w_inst_valid;
   logic [31:0] w_inst_32;
   logic [31:0] w_inst_pc_32;
   logic        w_inst_ready;
   logic        w_fetch_err;
   logic [31:0] w_perf_fetch_32;
   logic [31:0] w_perf_stall_32;

   int          errors = 0;
   int          checks = 0;

   logic        respPending;
   logic        stalePulse;
   logic        memGntEn;
   logic        sawReq;
   logic [31:0] respData;
   logic [31:0] issued[$];

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .w_stall(w_stall), .w_redirect(w_redirect),
      .w_next_pc_32(w_next_pc_32), .w_pc_32(w_pc_32), .w_imem_req(w_imem_req),
      .w_imem_addr_32(w_imem_addr_32), .w_imem_gnt(w_imem_gnt),
      .w_imem_rvalid(w_imem_rvalid), .w_imem_rdata_32(w_imem_rdata_32),
      .w_inst_valid(w_inst_valid), .w_inst_32(w_inst_32), .w_inst_pc_32(w_inst_pc_32),
      .w_inst_ready(w_inst_ready), .w_fetch_err(w_fetch_err),
      .w_perf_fetch_32(w_perf_fetch_32), .w_perf_stall_32(w_perf_stall_32)
   );

   always #5 w_clk = ~w_clk;

   // Watchdog so a wedged run still ends with a report.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One clock cycle: memory answers the current request, then the edge passes.
   task automatic tick();
      logic        nextPending;
      logic [31:0] nextData;
      #1;
      sawReq          = w_imem_req;
      w_imem_gnt      = w_imem_req & memGntEn;
      w_imem_rvalid   = respPending | stalePulse;
      w_imem_rdata_32 = respPending ? respData : 32'hDEAD_BEEF;
      nextPending     = 1'b0;
      nextData        = '0;
      if (w_imem_req && w_imem_gnt) begin
         issued.push_back(w_imem_addr_32);
         nextPending = 1'b1;
         nextData    = 32'hA500_0000 | w_imem_addr_32;
      end
      @(posedge w_clk);
      respPending = nextPending;
      respData    = nextData;
      @(negedge w_clk);
   endtask

   // Reset with default inputs; returns at a falling edge with reset released (cycle 0, IDLE).
   task automatic resetDut();
      w_rst = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_next_pc_32 = '0;
      w_inst_ready = 1'b1; w_imem_gnt = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata_32 = '0;
      respPending = 1'b0; stalePulse = 1'b0; memGntEn = 1'b1; respData = '0;
      issued.delete();
      @(negedge w_clk);
      @(negedge w_clk);
      w_rst = 1'b0;
   endtask

   // Reset values, IDLE cycle with no request, then first request at RESET_PC.
   task automatic test_reset();
      resetDut();
      w_rst = 1'b1;
      #1;
      checks++; if (w_imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", w_imem_req); end
      checks++; if (w_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", w_inst_valid); end
      checks++; if (w_inst_32 !== 32'h0 || w_inst_pc_32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h/%h expected 0/0", w_inst_32, w_inst_pc_32); end
      checks++; if (w_fetch_err !== 1'b0 || w_pc_32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_err_pc: got %b/%h expected 0/0", w_fetch_err, w_pc_32); end
      checks++; if (w_perf_fetch_32 !== 32'h0 || w_perf_stall_32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_perf: got %h/%h expected 0/0", w_perf_fetch_32, w_perf_stall_32); end
      @(negedge w_clk);
      w_rst = 1'b0;
      tick();
      checks++; if (sawReq !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req: got %b expected 0", sawReq); end
      tick();
      checks++; if (sawReq !== 1'b1 || issued.size() != 1) begin errors++; $display("[TB] FAIL first_req: got req=%b n=%0d expected req=1 n=1", sawReq, issued.size()); end
      else begin
         checks++; if (issued[0] !== 32'h0) begin errors++; $display("[TB] FAIL first_addr: got %h expected 00000000", issued[0]); end
      end
   endtask

   // Straight-line fetch 0x0,0x4,0x8 with first valid two cycles after the grant.
   task automatic test_sequential();
      resetDut();
      tick(); tick();
      checks++; if (w_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_wait_valid: got %b expected 0", w_inst_valid); end
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (w_inst_valid !== 1'b1 || w_inst_pc_32 !== 32'(4 * k) || w_inst_32 !== (32'hA500_0000 | 32'(4 * k))) begin
            errors++;
            $display("[TB] FAIL seq_inst%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                     k, w_inst_valid, w_inst_pc_32, w_inst_32, 32'(4 * k), 32'hA500_0000 | 32'(4 * k));
         end
         tick(); tick();
      end
      checks++;
      if (issued.size() < 3 || issued[0] !== 32'h0 || issued[1] !== 32'h4 || issued[2] !== 32'h8) begin
         errors++; $display("[TB] FAIL seq_addrs: got n=%0d expected 0,4,8 issued first", issued.size());
      end
   endtask

   // Branch at 0x8 to 0x100: delay slot 0xC delivered, then 0x100, 0x104 fetched.
   task automatic test_branch();
      resetDut();
      repeat (7) tick();
      checks++; if (w_inst_pc_32 !== 32'h8 || w_inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL br_at8: got pc=%h v=%b expected 00000008 1", w_inst_pc_32, w_inst_valid); end
      w_redirect = 1'b1; w_next_pc_32 = 32'h100;
      tick();
      w_redirect = 1'b0; w_next_pc_32 = 32'h0;
      tick();
      checks++; if (w_inst_pc_32 !== 32'hC || w_inst_32 !== 32'hA500_000C) begin errors++; $display("[TB] FAIL br_delay_slot: got pc=%h inst=%h expected 0000000c a500000c", w_inst_pc_32, w_inst_32); end
      checks++; if (w_pc_32 !== 32'h100) begin errors++; $display("[TB] FAIL br_pc_target: got %h expected 00000100", w_pc_32); end
      tick(); tick();
      checks++; if (w_inst_pc_32 !== 32'h100 || w_inst_32 !== 32'hA500_0100) begin errors++; $display("[TB] FAIL br_target_inst: got pc=%h inst=%h expected 00000100 a5000100", w_inst_pc_32, w_inst_32); end
      tick();
      checks++;
      if (issued.size() != 6 || issued[3] !== 32'hC || issued[4] !== 32'h100 || issued[5] !== 32'h104) begin
         errors++; $display("[TB] FAIL br_addrs: got n=%0d expected 6 ending c,100,104", issued.size());
      end
   endtask

   // Branch at 0x10 to 0x200: after the 0x14 slot is captured pc is 0x200 and 0x18 is never fetched.
   task automatic test_delay_slot_redirect();
      logic saw18;
      resetDut();
      repeat (11) tick();
      checks++; if (w_inst_pc_32 !== 32'h10) begin errors++; $display("[TB] FAIL ds_at10: got %h expected 00000010", w_inst_pc_32); end
      w_redirect = 1'b1; w_next_pc_32 = 32'h200;
      tick();
      w_redirect = 1'b0;
      tick();
      checks++; if (w_inst_pc_32 !== 32'h14 || w_pc_32 !== 32'h200) begin errors++; $display("[TB] FAIL ds_slot_pc: got inst_pc=%h pc=%h expected 00000014 00000200", w_inst_pc_32, w_pc_32); end
      tick(); tick();
      checks++; if (w_inst_pc_32 !== 32'h200 || w_inst_32 !== 32'hA500_0200) begin errors++; $display("[TB] FAIL ds_target: got pc=%h inst=%h expected 00000200 a5000200", w_inst_pc_32, w_inst_32); end
      saw18 = 1'b0;
      foreach (issued[i]) if (issued[i] == 32'h18) saw18 = 1'b1;
      checks++; if (saw18 !== 1'b0 || issued.size() != 7) begin errors++; $display("[TB] FAIL ds_no_18: got saw18=%b n=%0d expected 0 7", saw18, issued.size()); end
   endtask

   // Full buffer with ready low for five cycles: no requests, stable word, stall counter +5.
   task automatic test_backpressure();
      resetDut();
      repeat (3) tick();
      w_inst_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (sawReq !== 1'b0 || w_inst_32 !== 32'hA500_0000 || w_inst_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_hold%0d: got req=%b inst=%h v=%b expected 0 a5000000 1", c, sawReq, w_inst_32, w_inst_valid);
         end
      end
      checks++; if (w_perf_stall_32 !== 32'(PERF_ON * 5)) begin errors++; $display("[TB] FAIL bp_perf_stall: got %0d expected %0d", w_perf_stall_32, PERF_ON * 5); end
      checks++; if (issued.size() != 1) begin errors++; $display("[TB] FAIL bp_no_issue: got %0d expected 1", issued.size()); end
      w_inst_ready = 1'b1;
      tick(); tick();
      checks++; if (w_inst_pc_32 !== 32'h4 || w_inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume: got pc=%h v=%b expected 00000004 1", w_inst_pc_32, w_inst_valid); end
      checks++; if (w_perf_fetch_32 !== 32'(PERF_ON * 2)) begin errors++; $display("[TB] FAIL bp_perf_fetch: got %0d expected %0d", w_perf_fetch_32, PERF_ON * 2); end
   endtask

   // Stall blocks new requests but a raised request stays up until granted.
   task automatic test_stall();
      resetDut();
      w_stall = 1'b1;
      repeat (4) tick();
      checks++; if (issued.size() != 0 || w_pc_32 !== 32'h0) begin errors++; $display("[TB] FAIL st_block: got n=%0d pc=%h expected 0 00000000", issued.size(), w_pc_32); end
      checks++; if (w_perf_stall_32 !== 32'(PERF_ON * 4)) begin errors++; $display("[TB] FAIL st_perf: got %0d expected %0d", w_perf_stall_32, PERF_ON * 4); end
      w_stall = 1'b0; memGntEn = 1'b0;
      tick();
      checks++; if (sawReq !== 1'b1) begin errors++; $display("[TB] FAIL st_raise: got %b expected 1", sawReq); end
      w_stall = 1'b1;
      tick();
      checks++; if (sawReq !== 1'b1) begin errors++; $display("[TB] FAIL st_held: got %b expected 1", sawReq); end
      memGntEn = 1'b1;
      tick();
      checks++; if (issued.size() != 1) begin errors++; $display("[TB] FAIL st_granted: got %0d expected 1", issued.size()); end
      tick();
      checks++; if (w_inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL st_inflight: got %b expected 1", w_inst_valid); end
      tick();
      checks++; if (sawReq !== 1'b0) begin errors++; $display("[TB] FAIL st_no_new: got %b expected 0", sawReq); end
   endtask

   // Misaligned target 0x102: error sticks, slot 0xC delivered, no more requests; reset clears it.
   task automatic test_misaligned();
      resetDut();
      repeat (7) tick();
      w_redirect = 1'b1; w_next_pc_32 = 32'h102;
      tick();
      w_redirect = 1'b0; w_next_pc_32 = 32'h0;
      checks++; if (w_fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_err: got %b expected 1", w_fetch_err); end
      tick();
      checks++; if (w_inst_valid !== 1'b1 || w_inst_pc_32 !== 32'hC) begin errors++; $display("[TB] FAIL mis_slot: got v=%b pc=%h expected 1 0000000c", w_inst_valid, w_inst_pc_32); end
      repeat (4) tick();
      checks++; if (issued.size() != 4 || sawReq !== 1'b0) begin errors++; $display("[TB] FAIL mis_halt: got n=%0d req=%b expected 4 0", issued.size(), sawReq); end
      checks++; if (w_fetch_err !== 1'b1 || w_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_sticky: got err=%b v=%b expected 1 0", w_fetch_err, w_inst_valid); end
      w_rst = 1'b1;
      #1;
      checks++; if (w_fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL mis_reset: got %b expected 0", w_fetch_err); end
   endtask

   // Reset while waiting for a response; stale rvalid pulses afterwards are dropped.
   task automatic test_reset_mid();
      resetDut();
      tick(); tick();
      #2;
      w_rst = 1'b1;
      #1;
      checks++; if (w_imem_req !== 1'b0 || w_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async: got req=%b v=%b expected 0 0", w_imem_req, w_inst_valid); end
      respPending = 1'b0;
      @(negedge w_clk);
      w_rst = 1'b0;
      issued.delete();
      stalePulse = 1'b1;
      tick();
      checks++; if (w_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale_idle: got %b expected 0", w_inst_valid); end
      tick();
      stalePulse = 1'b0;
      checks++; if (w_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale_req: got %b expected 0", w_inst_valid); end
      checks++; if (issued.size() != 1) begin errors++; $display("[TB] FAIL mid_reissue: got n=%0d expected 1", issued.size()); end
      else begin
         checks++; if (issued[0] !== 32'h0) begin errors++; $display("[TB] FAIL mid_reissue_addr: got %h expected 00000000", issued[0]); end
      end
      tick();
      checks++; if (w_inst_valid !== 1'b1 || w_inst_32 !== 32'hA500_0000 || w_inst_pc_32 !== 32'h0) begin
         errors++; $display("[TB] FAIL mid_fresh: got v=%b inst=%h pc=%h expected 1 a5000000 00000000", w_inst_valid, w_inst_32, w_inst_pc_32);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_delay_slot_redirect();
      test_backpressure();
      test_stall();
      test_misaligned();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
